// File: rtl/vram_pkg.sv
// vram_pkg: VRAM geometry shared by the write front end and the display scanout,
// plus the write-side state encoding.
package vram_pkg;
    localparam int VRAM_AW = 13;
    localparam int VRAM_DW = 16;
    localparam int VRAM_WORDS = 8192;
    localparam logic [VRAM_AW-1:0] VRAM_LAST = 13'd8191;
    typedef enum logic [1:0] {RUN, DRAIN, CLEAR} vram_wr_state_t;
endpackage

// File: rtl/vram_wr_fifo.sv
// vram_wr_fifo: synchronous FIFO with combinational head data.
// DEPTH must be a power of two, at least 2.
module vram_wr_fifo #(
    parameter int DEPTH = 4,
    parameter int DW = 29
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data,
    output logic          o_full,
    output logic          o_empty
);
    localparam int AW = $clog2(DEPTH);
    logic [DW-1:0] r_mem [DEPTH];
    logic [AW:0] r_wptr, r_rptr;
    // Extra pointer bit separates full from empty when the indices match.
    assign o_empty = r_wptr == r_rptr;
    assign o_full = (r_wptr[AW-1:0] == r_rptr[AW-1:0]) && (r_wptr[AW] != r_rptr[AW]);
    assign o_data = r_mem[r_rptr[AW-1:0]];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (i_push) r_wptr <= r_wptr + 1'b1;
            if (i_pop) r_rptr <= r_rptr + 1'b1;
        end
    end
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wptr[AW-1:0]] <= i_data;
    end
endmodule

// File: rtl/vram_writer.sv
// vram_writer: buffers CPU screen writes and drains them into the VRAM write port.
// Defining VRAM_CLEAR_EN adds the full-screen clear engine (DRAIN/CLEAR states).
module vram_writer
    import vram_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter logic [VRAM_DW-1:0] CLEAR_VALUE = 16'h0000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cpu_valid,
    input  logic [VRAM_AW-1:0] cpu_addr,
    input  logic [VRAM_DW-1:0] cpu_data,
    output logic               cpu_ready,
    input  logic               clear_req,
    output logic               busy,
    output logic               clear_done,
    input  logic               vram_wgrant,
    output logic               vram_wren,
    output logic [VRAM_AW-1:0] vram_waddr,
    output logic [VRAM_DW-1:0] vram_wdata
);
    localparam int FW = VRAM_AW + VRAM_DW;
    logic [FW-1:0] w_head;
    logic w_full, w_empty, w_push, w_pop, w_clr_wr;
    vram_wr_state_t w_state;
    logic [VRAM_AW-1:0] w_clr_cnt;

    assign cpu_ready = rst_n && (w_state == RUN) && !w_full;
    assign w_push = cpu_valid && cpu_ready;
    assign w_pop = vram_wgrant && !w_empty && (w_state != CLEAR);
    assign w_clr_wr = vram_wgrant && (w_state == CLEAR);
    assign vram_wren = w_pop || w_clr_wr;
    assign vram_waddr = w_clr_wr ? w_clr_cnt : w_empty ? '0 : w_head[FW-1 -: VRAM_AW];
    assign vram_wdata = w_clr_wr ? CLEAR_VALUE : w_empty ? '0 : w_head[VRAM_DW-1:0];

    vram_wr_fifo #(.DEPTH(DEPTH), .DW(FW)) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  ({cpu_addr, cpu_data}),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

`ifdef VRAM_CLEAR_EN
    vram_wr_state_t r_state;
    logic [VRAM_AW-1:0] r_clr_cnt;
    logic r_busy, r_done;
    // busy and clear_done are registered alongside the state so they track it exactly.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
            r_clr_cnt <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                RUN: if (clear_req) begin
                    r_state <= DRAIN;
                    r_busy <= 1'b1;
                end
                DRAIN: if (w_empty) begin
                    r_state <= CLEAR;
                    r_clr_cnt <= '0;
                end
                CLEAR: if (vram_wgrant) begin
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == VRAM_LAST) begin
                        r_state <= RUN;
                        r_busy <= 1'b0;
                        r_done <= 1'b1;
                    end
                end
                default: r_state <= RUN;
            endcase
        end
    end
    assign w_state = r_state;
    assign w_clr_cnt = r_clr_cnt;
    assign busy = r_busy;
    assign clear_done = r_done;
`else
    logic w_unused;
    assign w_unused = clear_req;
    assign w_state = RUN;
    assign w_clr_cnt = '0;
    assign busy = 1'b0;
    assign clear_done = 1'b0;
`endif
endmodule

// File: tb/tb_vram_writer.sv
// tb_vram_writer: randomized scoreboard bench for vram_writer; clear tests run when
// VRAM_CLEAR_EN is defined, otherwise the bench checks that clear requests are ignored.
module tb_vram_writer;
    localparam logic [15:0] CV = 16'h5A3C;
    logic clk = 1'b0, rst_n = 1'b0, cpu_valid = 1'b0, clear_req = 1'b0, vram_wgrant = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [15:0] cpu_data = '0;
    logic cpu_ready, busy, clear_done, vram_wren;
    logic [12:0] vram_waddr;
    logic [15:0] vram_wdata;
    int n_checks = 0, n_fail = 0, n_writes = 0, n_done = 0, clr_left = 0;
    logic exp_done = 1'b0;
    logic [29:0] exp_q[$];

    always #5 clk = ~clk;

    vram_writer #(.DEPTH(4), .CLEAR_VALUE(CV)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_valid(cpu_valid), .cpu_addr(cpu_addr),
        .cpu_data(cpu_data), .cpu_ready(cpu_ready), .clear_req(clear_req), .busy(busy),
        .clear_done(clear_done), .vram_wgrant(vram_wgrant), .vram_wren(vram_wren),
        .vram_waddr(vram_waddr), .vram_wdata(vram_wdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Acceptance side: expected writes are queued as handshakes complete.
    always @(negedge clk) begin : acceptor
        logic acc, clr;
        acc = rst_n && cpu_valid && cpu_ready;
        clr = rst_n && clear_req && clr_left == 0;
        #1;
        if (acc) exp_q.push_back({1'b0, cpu_addr, cpu_data});
`ifdef VRAM_CLEAR_EN
        if (clr) begin
            clr_left = 8192;
            for (int i = 0; i < 8192; i++) exp_q.push_back({1'b1, 13'(i), CV});
        end
`else
        if (clr) clr_left = 0;
`endif
    end

    // Output side: every VRAM write must match the head of the expected queue.
    always @(negedge clk) begin : monitor
        logic [29:0] e;
        if (!rst_n) exp_done = 1'b0;
        else begin
            check("clear_done", {31'b0, clear_done}, {31'b0, exp_done});
            exp_done = 1'b0;
`ifndef VRAM_CLEAR_EN
            check("busy_off", {31'b0, busy}, 32'd0);
`endif
            if (clear_done) n_done++;
            if (vram_wren) begin
                n_writes++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, required no write", vram_waddr, vram_wdata);
                end else begin
                    e = exp_q.pop_front();
                    check("write", {3'b0, vram_waddr, vram_wdata}, {3'b0, e[28:0]});
                    if (e[29]) begin
                        clr_left--;
                        if (clr_left == 0) exp_done = 1'b1;
                    end
                end
            end
        end
    end

    task automatic wait_empty(input int bound, input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check(name, exp_q.size(), 0);
    endtask

    initial begin
        int acc, k, w0, n;
        logic adv;
        // reset state
        #12;
        check("rst_ready", {31'b0, cpu_ready}, 0);
        check("rst_wren", {31'b0, vram_wren}, 0);
        check("rst_waddr", {19'b0, vram_waddr}, 0);
        check("rst_wdata", {16'b0, vram_wdata}, 0);
        check("rst_busy", {31'b0, busy}, 0);
        tick();
        rst_n = 1'b1;
        // single write
        cpu_valid = 1'b1; cpu_addr = 13'h0010; cpu_data = 16'hA5A5; vram_wgrant = 1'b1;
        @(negedge clk);
        check("single_ready", {31'b0, cpu_ready}, 1);
        tick();
        cpu_valid = 1'b0;
        @(negedge clk);
        check("single_wren", {31'b0, vram_wren}, 1);
        check("single_word", {3'b0, vram_waddr, vram_wdata}, {3'b0, 13'h0010, 16'hA5A5});
        tick();
        @(negedge clk);
        check("single_empty_wren", {31'b0, vram_wren}, 0);
        check("single_empty_addr", {19'b0, vram_waddr}, 0);
        // backpressure
        tick();
        vram_wgrant = 1'b0; acc = 0; k = 0;
        cpu_valid = 1'b1; cpu_addr = 13'd100; cpu_data = 16'($urandom);
        repeat (8) begin
            @(negedge clk);
            adv = cpu_ready;
            if (adv) acc++;
            tick();
            if (adv && k < 4) begin
                k++;
                cpu_addr = 13'(100 + k);
                cpu_data = 16'($urandom);
            end
        end
        check("bp_accepted", acc, 4);
        vram_wgrant = 1'b1;
        @(negedge clk);
        check("bp_no_bypass", {31'b0, cpu_ready}, 0);
        check("bp_wren0", {31'b0, vram_wren}, 1);
        tick();
        @(negedge clk);
        check("bp_ready_back", {31'b0, cpu_ready}, 1);
        check("bp_wren1", {31'b0, vram_wren}, 1);
        tick();
        cpu_valid = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("bp_wren_run", {31'b0, vram_wren}, 1);
            tick();
        end
        @(negedge clk);
        check("bp_drained", {31'b0, vram_wren}, 0);
        // throughput
        tick();
        for (int i = 0; i < 40; i++) begin
            cpu_valid = 1'b1; cpu_addr = 13'($urandom); cpu_data = 16'($urandom);
            @(negedge clk);
            check("tp_ready", {31'b0, cpu_ready}, 1);
            if (i > 0) check("tp_wren", {31'b0, vram_wren}, 1);
            tick();
        end
        cpu_valid = 1'b0;
        // random traffic
        for (int i = 0; i < 400; i++) begin
            cpu_valid = 1'($urandom); vram_wgrant = ($urandom % 4) != 0;
            cpu_addr = 13'($urandom); cpu_data = 16'($urandom);
            tick();
        end
        cpu_valid = 1'b0; vram_wgrant = 1'b1;
        wait_empty(20, "rand_drain");
        tick();
`ifdef VRAM_CLEAR_EN
        // clear with pending data; the 4th beat shares its cycle with clear_req
        vram_wgrant = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cpu_valid = 1'b1; cpu_addr = 13'($urandom); cpu_data = 16'($urandom);
            clear_req = (i == 3);
            @(negedge clk);
            check("clr_pre_ready", {31'b0, cpu_ready}, 1);
            tick();
        end
        cpu_valid = 1'b0; clear_req = 1'b0;
        @(negedge clk);
        check("clr_busy", {31'b0, busy}, 1);
        check("clr_ready_low", {31'b0, cpu_ready}, 0);
        w0 = n_done; n = 0;
        tick();
        while (clr_left > 0 && n < 40000) begin
            vram_wgrant = 1'($urandom);
            clear_req = (n == 3000);
            tick();
            n++;
        end
        clear_req = 1'b0; vram_wgrant = 1'b1;
        check("clr_finished", clr_left, 0);
        wait_empty(10, "clr_queue_empty");
        tick();
        @(negedge clk);
        check("clr_busy_fall", {31'b0, busy}, 0);
        check("clr_ready_back", {31'b0, cpu_ready}, 1);
        check("clr_done_once", n_done - w0, 1);
        // reset mid-clear at clr_cnt 4000
        tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0; n = 0;
        while (clr_left != 8192 - 4000 && n < 10000) begin
            tick();
            n++;
        end
        check("rst_mid_reached", clr_left, 8192 - 4000);
        rst_n = 1'b0;
        #1;
        check("rstc_wren", {31'b0, vram_wren}, 0);
        check("rstc_word", {3'b0, vram_waddr, vram_wdata}, 0);
        check("rstc_busy", {31'b0, busy}, 0);
        check("rstc_ready", {31'b0, cpu_ready}, 0);
        exp_q.delete();
        clr_left = 0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rstc_ready_after", {31'b0, cpu_ready}, 1);
        check("rstc_busy_after", {31'b0, busy}, 0);
        w0 = n_writes;
        repeat (20) tick();
        check("rstc_no_writes", n_writes - w0, 0);
`else
        // clear requests have no effect without the clear engine
        for (int i = 0; i < 10; i++) begin
            cpu_valid = 1'b1; cpu_addr = 13'($urandom); cpu_data = 16'($urandom);
            clear_req = (i % 3 == 0);
            @(negedge clk);
            check("noclr_ready", {31'b0, cpu_ready}, 1);
            tick();
        end
        cpu_valid = 1'b0; clear_req = 1'b0;
        wait_empty(10, "noclr_drain");
        check("noclr_done_count", n_done, 0);
`endif
        // reset with data still queued
        tick();
        vram_wgrant = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cpu_valid = 1'b1; cpu_addr = 13'($urandom); cpu_data = 16'($urandom);
            tick();
        end
        cpu_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("rstf_ready", {31'b0, cpu_ready}, 0);
        check("rstf_word", {3'b0, vram_waddr, vram_wdata}, 0);
        exp_q.delete();
        tick();
        rst_n = 1'b1;
        vram_wgrant = 1'b1;
        w0 = n_writes;
        repeat (10) tick();
        check("rstf_no_writes", n_writes - w0, 0);
        check("final_queue", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/vram_writer.md
Name: vram_writer

Overview:
- Write-side front end of the screen VRAM; the display scanout is the read side.
- Accepts CPU screen-memory writes (13-bit word address, 16-bit pixel word) over a valid/ready handshake.
- Buffers the writes in a small FIFO and drains them into the VRAM write port whenever the arbiter grants a slot.
- Includes a hardware clear-screen engine that fills all 8192 words with a constant.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- CLEAR_VALUE, 16'h0000, word written by the clear engine (0 = white after display inversion).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cpu_valid  in  1  CPU write request
- cpu_addr  in  13  word address (y*32 + x/16)
- cpu_data  in  16  pixel word, bit n = pixel x%16==n
- cpu_ready  out  1  request accepted when valid&&ready
- clear_req  in  1  single-cycle pulse: start full-screen clear
- busy  out  1  high while draining for a clear, or clearing
- clear_done  out  1  one-cycle pulse after the last clear word is written
- vram_wgrant  in  1  arbiter permits a VRAM write this cycle
- vram_wren  out  1  VRAM write strobe
- vram_waddr  out  13  VRAM write address
- vram_wdata  out  16  VRAM write data

Behaviour:
- Reset (async assert, sync release): FIFO empty, state RUN, clear counter 0, busy=0, clear_done=0. vram_wren=0, vram_waddr=0, vram_wdata=0. cpu_ready=0 while rst_n low.
- States:
  - RUN: normal operation.
  - DRAIN: flushing the FIFO before a clear.
  - CLEAR: walking addresses 0..8191.
- cpu_ready = (state==RUN) && !full. No bypass: a push when full is impossible, even if a pop happens in the same cycle.
- Push and pop in the same cycle with the FIFO not full: count unchanged, order preserved.
- Write port is combinational from the FIFO head:
  - vram_wren = wgrant && (((RUN||DRAIN) && !empty) || CLEAR).
  - In RUN/DRAIN: waddr/wdata = head entry. In CLEAR: waddr = clr_cnt, wdata = CLEAR_VALUE.
  - When vram_wren=0: waddr/wdata hold the head entry, or 0 if the FIFO is empty.
- Pop occurs exactly when vram_wren is high in RUN/DRAIN.
- Minimum latency is 1 cycle: a word accepted at edge t appears on vram_w* in cycle t+1 if granted.
- Writes reach VRAM in acceptance order; nothing is dropped or duplicated.
- RUN + clear_req -> DRAIN. cpu_ready drops the next cycle; a beat accepted in the same cycle as clear_req is still queued and written.
- DRAIN -> CLEAR when the FIFO is empty; clr_cnt=0. If the FIFO is already empty, DRAIN lasts 1 cycle.
- CLEAR: clr_cnt advances only on wgrant. On a granted write with clr_cnt==8191, move to RUN and pulse clear_done in the next cycle. clr_cnt is 13 bits and wraps to 0.
- clear_req while in DRAIN or CLEAR is ignored.
- busy = (state != RUN).
- Reset mid-clear: abort immediately; a partially cleared screen is acceptable.

Optional Feature:
- Macro: VRAM_CLEAR_EN.
- Defined: clear engine, DRAIN/CLEAR states and clr_cnt are present as specified.
- Undefined: state is fixed at RUN; clear_req is ignored; busy=0 and clear_done=0 constantly; cpu_ready = !full.

Decomposition:
- Package vram_pkg:
  - VRAM_AW=13, VRAM_DW=16, VRAM_WORDS=8192, VRAM_LAST=13'd8191.
  - Enum vram_wr_state_t {RUN, DRAIN, CLEAR}; the display block shares the width constants.
- Sub-module vram_wr_fifo (DEPTH, data width 29): synchronous FIFO with push/pop/full/empty; head data combinational.

Test Plan:
- Single write: cpu_addr=13'h0010, data=16'hA5A5, wgrant=1 -> cpu_ready=1. Next cycle: wren=1, waddr=16, wdata=A5A5. FIFO empty after.
- Backpressure: wgrant=0, push 5 beats, DEPTH=4 -> ready drops after 4 acceptances. Raise wgrant -> 4 writes in order on consecutive cycles, then the 5th beat is accepted.
- Throughput: wgrant=1, cpu_valid=1 continuously -> one write per cycle, ready stays 1, FIFO count stays ≤1.
- Clear with pending data: 3 beats queued, wgrant=0, pulse clear_req -> busy=1, ready=0. Grant on -> 3 queued writes first, then 8192 writes of CLEAR_VALUE to addresses 0..8191. clear_done pulses once; busy falls in the same cycle; ready returns to 1.
- Grant gaps during clear: wgrant toggling 1/0 -> no address skipped or repeated; done after exactly 8192 granted cycles. A second clear_req mid-clear is ignored.
- Async reset at clr_cnt=4000 -> all outputs 0 immediately. After release: state RUN, ready=1, no further clear writes.
